// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage.
// Flag bit positions, default widths and the per-beat bundle.
package alu_pkg;

  localparam int N_DEF     = 32;
  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 16;

  localparam int FLG_ZERO = 0;
  localparam int FLG_COUT = 1;
  localparam int FLG_OVF  = 2;

  typedef struct packed {
    logic [N_DEF-1:0]     result;
    logic                 cout;
    logic                 zero;
    logic                 overflow;
    logic [REG_W_DEF-1:0] rd;
    logic                 wr_en;
    logic                 flags_en;
  } alu_beat_t;

  function automatic logic [2:0] pack_flags(
    input logic ovf,
    input logic cout,
    input logic zero
  );
    logic [2:0] f;
    f           = '0;
    f[FLG_OVF]  = ovf;
    f[FLG_COUT] = cout;
    f[FLG_ZERO] = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_result_stage_status.sv
// Architectural status: last flags, sticky overflow, retire count.
// In: ret_i + head flags, clr_sticky_i. Out: flags, sticky, count.
module alu_status_reg
  import alu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ret_i,
  input  logic             flags_en_i,
  input  logic             ovf_i,
  input  logic             cout_i,
  input  logic             zero_i,
  input  logic             clr_sticky_i,
  output logic [2:0]       status_flags_o,
  output logic             sticky_ovf_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  logic [2:0]       flags_q, flags_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             upd;

  assign upd = ret_i & flags_en_i;

  always_comb begin
    flags_d = flags_q;
    if (upd) begin
      flags_d = pack_flags(ovf_i, cout_i, zero_i);
    end
  end

  // A set in the same cycle as a clear wins.
  always_comb begin
    sticky_d = sticky_q & ~clr_sticky_i;
    if (upd && ovf_i) begin
      sticky_d = 1'b1;
    end
  end

  // Free-running wrap, no saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (ret_i) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign status_flags_o = flags_q;
  assign sticky_ovf_o   = sticky_q;
  assign retired_cnt_o  = cnt_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage with 2-entry skid buffer to writeback.
// in_* handshake upstream, out_* to writeback, plus status outputs.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_result,
  input  logic             in_cout,
  input  logic             in_zero,
  input  logic             in_overflow,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_wr_en,
  input  logic             in_flags_en,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [REG_W-1:0] out_rd,
  output logic             out_wr_en,
  output logic [2:0]       status_flags,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef struct packed {
    logic [N-1:0]     result;
    logic             cout;
    logic             zero;
    logic             overflow;
    logic [REG_W-1:0] rd;
    logic             wr_en;
    logic             flags_en;
  } beat_t;

  beat_t in_beat;
  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  logic  main_valid_q, main_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  acc, ret;
  logic  do_flush, do_drain, do_load, do_skid;

  always_comb begin
    in_beat          = '0;
    in_beat.result   = in_result;
    in_beat.cout     = in_cout;
    in_beat.zero     = in_zero;
    in_beat.overflow = in_overflow;
    in_beat.rd       = in_rd;
    in_beat.wr_en    = in_wr_en;
    in_beat.flags_en = in_flags_en;
  end

  // Ready depends only on a register.
  assign in_ready = ~skid_valid_q;
  assign acc      = in_valid & in_ready;
  assign ret      = main_valid_q & out_ready;

  // Mutually exclusive selects; acc cannot occur with skid full.
  assign do_flush = flush;
  assign do_drain = ~flush & skid_valid_q;
  assign do_load  = ~flush & ~skid_valid_q
                  & (~main_valid_q | ret);
  assign do_skid  = ~flush & ~skid_valid_q
                  & main_valid_q & ~ret;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    unique case (1'b1)
      do_flush: begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
      do_drain: begin
        if (ret) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end
      end
      do_load: begin
        main_valid_d = acc;
        if (acc) begin
          main_d = in_beat;
        end
      end
      do_skid: begin
        if (acc) begin
          skid_d       = in_beat;
          skid_valid_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid  = main_valid_q;
  assign out_result = main_q.result;
  assign out_rd     = main_q.rd;
  assign out_wr_en  = main_q.wr_en;

  alu_status_reg #(
    .CNT_W(CNT_W)
  ) u_status (
    .clk           (clk),
    .rst_n         (rst_n),
    .ret_i         (ret),
    .flags_en_i    (main_q.flags_en),
    .ovf_i         (main_q.overflow),
    .cout_i        (main_q.cout),
    .zero_i        (main_q.zero),
    .clr_sticky_i  (clr_sticky),
    .status_flags_o(status_flags),
    .sticky_ovf_o  (sticky_ovf),
    .retired_cnt_o (retired_cnt)
  );

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios then random traffic.
// Reference is a FIFO queue of beats plus scalar status state.
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int N     = 32;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_result;
  logic             in_cout;
  logic             in_zero;
  logic             in_overflow;
  logic [REG_W-1:0] in_rd;
  logic             in_wr_en;
  logic             in_flags_en;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_result;
  logic [REG_W-1:0] out_rd;
  logic             out_wr_en;
  logic [2:0]       status_flags;
  logic             sticky_ovf;
  logic             clr_sticky;
  logic [CNT_W-1:0] retired_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  alu_beat_t  mq[$];
  logic [2:0] m_flags;
  bit         m_sticky;
  int         m_cnt;

  always #5 clk = ~clk;

  alu_result_stage #(
    .N(N), .REG_W(REG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_cout(in_cout),
    .in_zero(in_zero), .in_overflow(in_overflow),
    .in_rd(in_rd), .in_wr_en(in_wr_en),
    .in_flags_en(in_flags_en), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .status_flags(status_flags),
    .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky),
    .retired_cnt(retired_cnt)
  );

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_flags  = 3'b000;
    m_sticky = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".in_ready"}, in_ready, mq.size() < 2);
    chk({tag, ".out_valid"}, out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk({tag, ".result"}, out_result, mq[0].result);
      chk({tag, ".rd"}, out_rd, mq[0].rd);
      chk({tag, ".wr_en"}, out_wr_en, mq[0].wr_en);
    end
    chk({tag, ".flags"}, status_flags, m_flags);
    chk({tag, ".sticky"}, sticky_ovf, m_sticky);
    chk({tag, ".cnt"}, retired_cnt, m_cnt % (1 << CNT_W));
  endtask

  task automatic set_beat(logic [N-1:0] r, logic [REG_W-1:0] rd,
                          bit we, bit fe, bit ovf, bit co, bit z);
    in_valid    = 1'b1;
    in_result   = r;
    in_rd       = rd;
    in_wr_en    = we;
    in_flags_en = fe;
    in_overflow = ovf;
    in_cout     = co;
    in_zero     = z;
  endtask

  task automatic rand_beat();
    set_beat($urandom, REG_W'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom));
  endtask

  // One clock: predict from inputs, advance, compare.
  task automatic cycle(string tag);
    bit        ret, acc, fl, clr;
    alu_beat_t b, h;
    ret        = (mq.size() > 0) && out_ready;
    acc        = in_valid && (mq.size() < 2);
    fl         = flush;
    clr        = clr_sticky;
    b          = '0;
    b.result   = in_result;
    b.cout     = in_cout;
    b.zero     = in_zero;
    b.overflow = in_overflow;
    b.rd       = in_rd;
    b.wr_en    = in_wr_en;
    b.flags_en = in_flags_en;
    @(posedge clk);
    #1;
    m_sticky = m_sticky && !clr;
    if (ret) begin
      h = mq.pop_front();
      if (h.flags_en) begin
        m_flags = {h.overflow, h.cout, h.zero};
        if (h.overflow) m_sticky = 1'b1;
      end
      m_cnt++;
    end
    if (fl) mq.delete();
    else if (acc) mq.push_back(b);
    check_all(tag);
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    flush      = 1'b0;
    clr_sticky = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #3;
    model_clear();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset");
  endtask

  initial begin
    in_result   = '0;
    in_rd       = '0;
    in_wr_en    = 1'b0;
    in_flags_en = 1'b0;
    in_overflow = 1'b0;
    in_cout     = 1'b0;
    in_zero     = 1'b0;
    model_clear();
    do_reset();

    // Single beat
    out_ready = 1'b1;
    set_beat(32'h0000_0007, 5'd3, 1, 1, 0, 0, 0);
    cycle("single.acc");
    chk("single.valid", out_valid, 1'b1);
    chk("single.result", out_result, 32'h7);
    idle();
    cycle("single.ret");
    chk("single.cnt", retired_cnt, 4'd1);
    chk("single.flags", status_flags, 3'b000);

    // Backpressure
    do_reset();
    set_beat(32'h11, 5'd1, 1, 0, 0, 0, 0);
    cycle("bp.a");
    set_beat(32'h22, 5'd2, 1, 0, 0, 0, 0);
    cycle("bp.b");
    chk("bp.ready_drop", in_ready, 1'b0);
    set_beat(32'h33, 5'd3, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("bp.hold");
    chk("bp.head_a", out_result, 32'h11);
    out_ready = 1'b1;
    cycle("bp.ret_a");
    chk("bp.head_b", out_result, 32'h22);
    cycle("bp.ret_b");
    chk("bp.head_c", out_result, 32'h33);
    idle();
    cycle("bp.ret_c");
    chk("bp.cnt", retired_cnt, 4'd3);

    // Flush with retire
    do_reset();
    set_beat(32'hAA, 5'd4, 1, 0, 0, 0, 0);
    cycle("fl.aa");
    set_beat(32'hBB, 5'd5, 1, 0, 0, 0, 0);
    cycle("fl.bb");
    out_ready = 1'b1;
    flush     = 1'b1;
    set_beat(32'hCC, 5'd6, 1, 0, 0, 0, 0);
    cycle("fl.go");
    idle();
    chk("fl.out_valid", out_valid, 1'b0);
    chk("fl.in_ready", in_ready, 1'b1);
    chk("fl.cnt", retired_cnt, 4'd1);
    cycle("fl.after");

    // Flags and sticky
    set_beat(32'h1, 5'd1, 1, 1, 1, 0, 0);
    cycle("fs.b1");
    idle();
    cycle("fs.b1r");
    chk("fs.flags1", status_flags, 3'b100);
    set_beat(32'h2, 5'd2, 1, 0, 0, 1, 1);
    cycle("fs.b2");
    idle();
    cycle("fs.b2r");
    chk("fs.flags2", status_flags, 3'b100);
    clr_sticky = 1'b1;
    cycle("fs.clr");
    chk("fs.cleared", sticky_ovf, 1'b0);
    set_beat(32'h3, 5'd3, 1, 1, 1, 0, 0);
    clr_sticky = 1'b0;
    cycle("fs.b3");
    idle();
    clr_sticky = 1'b1;
    cycle("fs.collide");
    chk("fs.sticky_win", sticky_ovf, 1'b1);
    idle();

    // Counter wrap
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rand_beat();
      cycle("wrap.stream");
    end
    idle();
    cycle("wrap.tail");
    chk("wrap.cnt", retired_cnt, 4'd1);

    // Async reset mid-stream
    out_ready = 1'b0;
    rand_beat();
    cycle("ar.m");
    rand_beat();
    cycle("ar.s");
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("ar.out_valid", out_valid, 1'b0);
    chk("ar.in_ready", in_ready, 1'b1);
    chk("ar.cnt", retired_cnt, 4'd0);
    chk("ar.flags", status_flags, 3'b000);
    chk("ar.sticky", sticky_ovf, 1'b0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("ar.release");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) rand_beat();
      else in_valid = 1'b0;
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 19) == 0);
      clr_sticky = ($urandom_range(0, 9) == 0);
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU arithmetic units (add/sub/mod).
- Captures each ALU result beat (N-bit result, cout, zero, overflow, destination register, write enable) and presents it to writeback over a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready purely registered. Throughput is 1 beat per cycle under backpressure.
- Also holds the architectural status flags, a sticky-overflow bit and a retired-beat counter.

Parameters:
- N, 32: datapath width of result.
- REG_W, 5: destination register index width.
- CNT_W, 16: retired-beat counter width.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat; equals NOT skid_valid.
- in_result  input  N  ALU result.
- in_cout  input  1  carry-out from ALU.
- in_zero  input  1  zero flag from ALU.
- in_overflow  input  1  overflow flag from ALU.
- in_rd  input  REG_W  destination register.
- in_wr_en  input  1  beat writes the register file.
- in_flags_en  input  1  beat updates status flags.
- flush  input  1  synchronous pipeline flush.
- out_valid  output  1  beat available to writeback.
- out_ready  input  1  writeback accepts.
- out_result  output  N  result of head beat.
- out_rd  output  REG_W  destination of head beat.
- out_wr_en  output  1  write enable of head beat.
- status_flags  output  3  {overflow, cout, zero} of last retired flag-setting beat.
- sticky_ovf  output  1  set by any retired overflow; cleared by clr_sticky.
- clr_sticky  input  1  clear sticky_ovf.
- retired_cnt  output  CNT_W  count of retired beats.

Behaviour:
- Reset (async, rst_n=0) values:
  - main_valid=0, skid_valid=0, in_ready=1, out_valid=0.
  - All data registers, status_flags, sticky_ovf and retired_cnt = 0.
- Definitions:
  - acc = in_valid & in_ready.
  - ret = out_valid & out_ready.
  - out_* are driven from the main register only; out_valid = main_valid.
- Latency: a beat accepted in cycle t is visible on out_* in cycle t+1. No combinational path from in_* or out_ready to any output.
- Per-cycle transitions, no flush (in_ready=0 whenever skid_valid=1, so acc implies skid empty):
  - main empty, acc: beat to main.
  - main valid, ret, acc: new beat to main (pass-through).
  - main valid, no ret, acc: beat to skid; in_ready drops next cycle.
  - skid valid, ret: skid to main; skid cleared; in_ready returns 1 next cycle.
  - main valid, ret, no acc, skid empty: main_valid=0.
- Beat ordering is strictly FIFO. No beat is ever dropped or duplicated without flush.
- Flush (synchronous, clk edge):
  - A beat retiring in the same cycle (ret=1) completes normally, including flag and counter update.
  - All other held beats and any beat accepted that cycle are discarded: main_valid=0, skid_valid=0.
  - flush has priority over acc.
- Status update, on ret only:
  - If head in_flags_en was 1, status_flags <= {overflow, cout, zero} of the head beat.
  - Otherwise status_flags hold.
- sticky_ovf:
  - Set on ret with flags_en=1 and overflow=1.
  - clr_sticky clears it.
  - A set in the same cycle as clr_sticky wins (result 1).
- retired_cnt increments by 1 on every ret, regardless of flags_en. Wraps from 2^CNT_W-1 to 0 with no saturation.
- Flags and wr_en are stored per beat in both main and skid. They are never taken from live inputs at retire time.
- Reset asserted mid-transfer: all beats are lost immediately (async). After rst_n rises, in_ready=1 on the first edge.

Decomposition:
- Shared package alu_pkg holds:
  - Flag bit indices FLG_ZERO=0, FLG_COUT=1, FLG_OVF=2.
  - Packed struct alu_beat_t {result, cout, zero, overflow, rd, wr_en, flags_en}, parameterised by the package constants N_DEF=32 and REG_W_DEF=5.
- One sub-module, alu_status_reg: holds status_flags, sticky_ovf and retired_cnt. Driven by ret and the head beat.
- The skid buffer logic stays inline in alu_result_stage.

Test Plan:
- Single beat:
  - Stimulus: reset, then one beat result=0x0000_0007, rd=3, wr_en=1, flags_en=1, flags {0,0,0}, out_ready=1.
  - Required: out_valid high exactly 1 cycle after acceptance; out_result=7; retired_cnt=1; status_flags=3'b000.
- Backpressure:
  - Stimulus: out_ready=0, send beats A=0x11, B=0x22, C=0x33 back-to-back; release out_ready after 3 cycles.
  - Required: in_ready=0 the cycle after B is accepted; C is held until in_ready returns; outputs retire in order 0x11, 0x22, 0x33; retired_cnt=3.
- Flush with retire:
  - Stimulus: main and skid both full (0xAA, 0xBB), out_ready=1, flush=1 in the same cycle.
  - Required: 0xAA retires and counts; 0xBB is discarded; out_valid=0 next cycle; in_ready=1.
- Flags and sticky:
  - Stimulus: retire a beat with overflow=1, flags_en=1, then a beat with flags_en=0, overflow=0; then a cycle with clr_sticky=1 and a retiring overflow beat together.
  - Required: status_flags=3'b100 after the first beat and unchanged after the second; sticky_ovf stays 1 in the collision cycle.
- Counter wrap:
  - Stimulus: CNT_W=4, retire 17 beats.
  - Required: retired_cnt=1.
- Async reset mid-stream:
  - Stimulus: rst_n=0 between clock edges while main and skid are full.
  - Required: out_valid=0 and in_ready=1 immediately; all counters and flags are 0.
